// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - instruction-memory read port shared by the fetch sequencer and the memory
interface instr_fetch_ctrl_if #(
    parameter int PC_WIDTH = 10
);
    logic                imem_en;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_data;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_data
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_data
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - PC owner and fetch/execute sequencer feeding instr0/instr1 to the datapath
// Optional macro SINGLE_STEP_EN: every non-END EXEC returns to HLT, so each start runs one instruction.
module instr_fetch_ctrl #(
    parameter int                  PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    instr_fetch_ctrl_if.master  imem,
    input  logic                jump_en,
    input  logic [PC_WIDTH-1:0] jump_addr,
    output logic [31:0]         instr0,
    output logic [31:0]         instr1,
    output logic [3:0]          current_state,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
);
    localparam logic [3:0] STATE_HLT      = 4'd0;
    localparam logic [3:0] STATE_FETCH0   = 4'd1;
    localparam logic [3:0] STATE_FETCH0_W = 4'd2;
    localparam logic [3:0] STATE_FETCH1   = 4'd3;
    localparam logic [3:0] STATE_FETCH1_W = 4'd4;
    localparam logic [3:0] STATE_EXEC     = 4'd5;

    localparam logic [7:0] OP_LIMM32 = 8'h03;
    localparam logic [7:0] OP_END    = 8'hFF;

    logic [3:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr0_q, instr0_d;
    logic [31:0]         instr1_q, instr1_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        case (state_q)
            STATE_HLT: begin
                if (start) state_d = STATE_FETCH0;
            end
            STATE_FETCH0: begin
                state_d = STATE_FETCH0_W;
            end
            STATE_FETCH0_W: begin
                instr0_d = imem.imem_data;
                instr1_d = '0;
                pc_d     = pc_q + 1'b1;
                state_d  = (imem.imem_data[31:24] == OP_LIMM32) ? STATE_FETCH1 : STATE_EXEC;
            end
            STATE_FETCH1: begin
                state_d = STATE_FETCH1_W;
            end
            STATE_FETCH1_W: begin
                instr1_d = imem.imem_data;
                pc_d     = pc_q + 1'b1;
                state_d  = STATE_EXEC;
            end
            STATE_EXEC: begin
                // END halts and suppresses any jump, leaving pc at the incremented value
                if (instr0_q[31:24] == OP_END) begin
                    state_d = STATE_HLT;
                end else begin
`ifdef SINGLE_STEP_EN
                    state_d = STATE_HLT;
`else
                    state_d = STATE_FETCH0;
`endif
                    if (jump_en) pc_d = jump_addr;
                end
            end
            default: begin
                state_d = STATE_HLT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= STATE_HLT;
            pc_q     <= RESET_PC;
            instr0_q <= '0;
            instr1_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
        end
    end

    // Memory port is decoded straight from state so the read issues in the FETCH cycle itself
    always_comb begin
        imem.imem_en   = (state_q == STATE_FETCH0) || (state_q == STATE_FETCH1);
        imem.imem_addr = imem.imem_en ? pc_q : '0;
    end

    assign instr0        = instr0_q;
    assign instr1        = instr1_q;
    assign current_state = state_q;
    assign pc            = pc_q;
    assign halted        = (state_q == STATE_HLT);
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - scoreboard bench for instr_fetch_ctrl with a synchronous-read memory model
module tb_instr_fetch_ctrl;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          jump_en = 1'b0;
    logic [PW-1:0] jump_addr = '0;
    logic [31:0]   instr0, instr1;
    logic [3:0]    current_state;
    logic [PW-1:0] pc;
    logic          halted;

    instr_fetch_ctrl_if #(.PC_WIDTH(PW)) bus ();

    instr_fetch_ctrl #(.PC_WIDTH(PW), .RESET_PC(10'h000)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .imem          (bus.master),
        .jump_en       (jump_en),
        .jump_addr     (jump_addr),
        .instr0        (instr0),
        .instr1        (instr1),
        .current_state (current_state),
        .pc            (pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic [31:0] rdata;
    always @(posedge clk) if (bus.imem_en) rdata <= mem[bus.imem_addr];
    assign bus.imem_data = rdata;

    typedef struct packed {
        logic [31:0]   w0;
        logic [31:0]   w1;
        logic [PW-1:0] pc;
        logic [31:0]   off;
    } exec_t;

    exec_t         exec_q[$];
    logic [PW-1:0] fetch_q[$];
    exec_t         mon_e;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    bit            mon_en = 1'b0;
    int            exec_idx = 0;
    int            jump_idx = -1;
    logic [PW-1:0] jump_tgt = '0;
    logic [PW-1:0] m_pc = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            check("state_legal", 32'(current_state <= 4'd5), 32'd1);
            check("halted_flag", 32'(halted), 32'(current_state == 4'd0));
            if (bus.imem_en) begin
                check("fetch_pending", 32'(fetch_q.size() != 0), 32'd1);
                if (fetch_q.size() != 0) check("fetch_addr", 32'(bus.imem_addr), 32'(fetch_q.pop_front()));
            end else begin
                check("idle_addr", 32'(bus.imem_addr), 32'd0);
            end
            jump_en = 1'b0;
            if (current_state == 4'd5) begin
                check("exec_pending", 32'(exec_q.size() != 0), 32'd1);
                if (exec_q.size() != 0) begin
                    mon_e = exec_q.pop_front();
                    check("exec_instr0", instr0, mon_e.w0);
                    check("exec_instr1", instr1, mon_e.w1);
                    check("exec_pc", 32'(pc), 32'(mon_e.pc));
                    check("exec_cycle", 32'(cyc - start_cyc), mon_e.off);
                end
                if (exec_idx == jump_idx) begin
                    jump_en   = 1'b1;
                    jump_addr = jump_tgt;
                end
                exec_idx++;
            end
        end
    end

    task automatic model_run(input int jidx, input logic [PW-1:0] jtgt);
        logic [31:0] off;
        exec_t       e;
        off = 0;
        for (int i = 0; i < 64; i++) begin
            fetch_q.push_back(m_pc);
            e.w0 = mem[m_pc];
            e.w1 = 32'h0;
            m_pc = m_pc + 1'b1;
            off  = off + 3;
            if (e.w0[31:24] == 8'h03) begin
                fetch_q.push_back(m_pc);
                e.w1 = mem[m_pc];
                m_pc = m_pc + 1'b1;
                off  = off + 2;
            end
            e.pc  = m_pc;
            e.off = off;
            exec_q.push_back(e);
            if (e.w0[31:24] == 8'hFF) break;
            if (i == jidx) m_pc = jtgt;
`ifdef SINGLE_STEP_EN
            break;
`endif
        end
    endtask

    task automatic run(input int jidx, input logic [PW-1:0] jtgt);
        int n;
        jump_idx = jidx;
        jump_tgt = jtgt;
        exec_idx = 0;
        model_run(jidx, jtgt);
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!halted && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("halt_reached", 32'(halted), 32'd1);
        @(negedge clk);
        check("exec_drained", 32'(exec_q.size()), 32'd0);
        check("fetch_drained", 32'(fetch_q.size()), 32'd0);
        check("pc_final", 32'(pc), 32'(m_pc));
        exec_q.delete();
        fetch_q.delete();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;

        #12;
        check("rst_state", 32'(current_state), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_instr0", instr0, 32'd0);
        check("rst_instr1", instr1, 32'd0);
        check("rst_imem_en", 32'(bus.imem_en), 32'd0);
        check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // LIMM16 then END; a jump requested on END must be ignored
        mem[0] = 32'h0204_0005;
        mem[1] = 32'hFF00_0000;
        run(1, 10'h155);

        // two-word LIMM32 followed by a one-word NOP that must show instr1=0
        mem[2] = 32'h0308_0000;
        mem[3] = 32'hDEAD_BEEF;
        mem[4] = 32'h0000_0000;
        mem[5] = 32'hFF00_0000;
        run(-1, '0);

        // jump during first EXEC redirects the next fetch to 0x10
        mem[6]     = 32'h0000_0000;
        mem[10'h10] = 32'hFF00_0000;
        run(0, 10'h010);

        // jump to the top address so the increment wraps to 0
        mem[10'h11]  = 32'h0000_0000;
        mem[10'h3FF] = 32'h0000_0000;
        run(0, 10'h3FF);

        // reset during FETCH1_W, then refetch from RESET_PC
        mon_en = 1'b0;
        mem[2] = 32'h0308_0000;
        mem[3] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (current_state != 4'd4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_fetch1_w", 32'(current_state), 32'd4);
        #1 reset = 1'b1;
        #1;
        check("arst_state", 32'(current_state), 32'd0);
        check("arst_pc", 32'(pc), 32'd0);
        check("arst_halted", 32'(halted), 32'd1);
        check("arst_instr0", instr0, 32'd0);
        check("arst_instr1", instr1, 32'd0);
        check("arst_imem_en", 32'(bus.imem_en), 32'd0);
        @(negedge clk);
        exec_q.delete();
        fetch_q.delete();
        m_pc   = '0;
        mem[0] = 32'h0308_0000;
        mem[1] = 32'hDEAD_BEEF;
        mem[2] = 32'hFF00_0000;
        reset  = 1'b0;
        mon_en = 1'b1;
        run(-1, '0);

        // NOP, NOP, END: one start per instruction when single-stepping
        mem[3] = 32'h0000_0000;
        mem[4] = 32'h0000_0000;
        mem[5] = 32'hFF00_0000;
`ifdef SINGLE_STEP_EN
        run(-1, '0);
        run(-1, '0);
        run(-1, '0);
`else
        run(-1, '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
